// File: rtl/seg_display_scheduler_pkg.sv
// Shared display constants: digit count, blanking values and the active-low hex glyph table.
// Glyph bits are {g,f,e,d,c,b,a}; a 0 lights the segment.
package display_pkg;

  localparam int DIGITS = 4;
  localparam int IDX_W  = $clog2(DIGITS);

  localparam logic [6:0]        BLANK_SEG  = 7'h7F;
  localparam logic [DIGITS-1:0] ALL_OFF_AN = 4'hF;

  typedef enum logic {
    ST_IDLE,
    ST_SHOW
  } disp_state_e;

  // Entry 15 first, so GLYPH_TABLE[n] is the glyph for hex digit n.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [DIGITS-1:0] digit_enable(input logic [IDX_W-1:0] idx);
    return ~(DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seg_display_scheduler_if.sv
// Requester/display bundle between the vending FSM side (master) and the scheduler (slave).
interface seg_display_scheduler_if #(
  parameter int NUM_REQ = 3
);
  import display_pkg::*;

  logic                    scan_tick;
  logic [NUM_REQ-1:0]      req;
  logic [16*NUM_REQ-1:0]   req_data;
  logic [NUM_REQ-1:0]      grant;
  logic [DIGITS-1:0]       an;
  logic [6:0]              seg;

  modport master (
    output scan_tick, req, req_data,
    input  grant, an, seg
  );

  modport slave (
    input  scan_tick, req, req_data,
    output grant, an, seg
  );

endinterface

// File: rtl/seg_display_scheduler_seg7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seg_display_scheduler.sv
// Fixed-priority owner arbitration with a minimum hold in frames, plus the 4-digit scan.
// Decisions and data latching happen only on the scan tick that wraps the last digit.
module seg_display_scheduler
  import display_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int HOLD_FRAMES = 2
) (
  input  logic                      masterClk,
  input  logic                      rst,
  seg_display_scheduler_if.slave    bus
);

  localparam int OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W  = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_FRAMES - 1);

  disp_state_e         state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [OWNER_W-1:0]  owner_q, owner_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [15:0]         data_q, data_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;

  logic                top_valid;
  logic [OWNER_W-1:0]  top_idx;
  logic                boundary;
  logic [3:0]          nibble;
  logic [6:0]          glyph;

  // Lowest index wins, so scan from the bottom of the priority order upward.
  always_comb begin
    top_valid = 1'b0;
    top_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        top_valid = 1'b1;
        top_idx   = OWNER_W'(i);
      end
    end
  end

  assign boundary = bus.scan_tick && (idx_q == IDX_W'(DIGITS - 1));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    data_d     = data_q;

    if (bus.scan_tick) begin
      idx_d = idx_q + 1'b1;
    end

    if (boundary) begin
      case (state_q)
        ST_IDLE: begin
          if (top_valid) begin
            state_d    = ST_SHOW;
            owner_d    = top_idx;
            hold_cnt_d = HOLD_LOAD;
          end
        end
        ST_SHOW: begin
          // A departing owner releases immediately, hold time notwithstanding.
          if (!bus.req[owner_q]) begin
            if (top_valid) begin
              owner_d    = top_idx;
              hold_cnt_d = HOLD_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - 1'b1;
          end else if (top_idx < owner_q) begin
            owner_d    = top_idx;
            hold_cnt_d = HOLD_LOAD;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (state_d == ST_SHOW) begin
        data_d = bus.req_data[16*owner_d +: 16];
      end
    end
  end

  assign nibble = data_d[4*idx_d +: 4];

  seg7_decode u_decode (
    .nibble (nibble),
    .seg    (glyph)
  );

  // Outputs are built from the next-state values so the new digit appears on the tick edge.
  always_comb begin
    grant_d = '0;
    an_d    = ALL_OFF_AN;
    seg_d   = BLANK_SEG;
    if (state_d == ST_SHOW) begin
      grant_d[owner_d] = 1'b1;
      an_d             = digit_enable(idx_d);
      seg_d            = glyph;
    end
  end

  always_ff @(posedge masterClk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      owner_q    <= '0;
      hold_cnt_q <= '0;
      data_q     <= '0;
      grant_q    <= '0;
      an_q       <= ALL_OFF_AN;
      seg_q      <= BLANK_SEG;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      data_q     <= data_d;
      grant_q    <= grant_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.an    = an_q;
  assign bus.seg   = seg_q;

endmodule

// File: doc/seg_display_scheduler.md
# seg_display_scheduler

Time-shares the vending machine's 4-digit seven-segment display between several requesters, such as credit, price and error/status. The arbitration is fixed-priority, with a minimum hold time per owner. The block also scans the digits, advancing on the divider's scan strobe. It sits between the vending FSM outputs and the board's anode/cathode pins, and runs entirely in the masterClk domain.

## Interface
- NUM_REQ, 3: number of requesters; index 0 has the highest priority.
- HOLD_FRAMES, 2: minimum number of full frames an owner is displayed before preemption; must be ≥1.
- masterClk  in  1  system clock; every register uses posedge masterClk.
- rst  in  1  synchronous, active-high reset.
- scan_tick  in  1  one-cycle strobe that advances the scan by one digit.
- req  in  NUM_REQ  level request per requester.
- req_data  in  16*NUM_REQ  four hex nibbles per requester; slice i is [16i+15:16i], and nibble 0 is the rightmost digit.
- grant  out  NUM_REQ  one-hot current owner; all zero when idle.
- an  out  4  digit anodes, active-low.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.

## Operation
- Internal state:
  - digit index idx, 0..3;
  - state IDLE or SHOW;
  - owner index;
  - hold_cnt;
  - 16-bit frame data latch.
- Frame boundary: a scan_tick that arrives while idx==3. Every scan_tick sets idx ← idx+1, wrapping 3→0.
- All arbitration decisions happen only at frame boundaries. req changes between boundaries have no effect.
- At a frame boundary in IDLE:
  - If any req is high: grant the highest-priority requester, latch its data, load hold_cnt ← HOLD_FRAMES-1, go to SHOW.
  - Otherwise stay in IDLE.
- At a frame boundary in SHOW, the first matching rule applies:
  1. Owner's req is low: grant the highest-priority pending requester (reload hold_cnt, latch data), or go to IDLE if none is pending. Hold time is ignored.
  2. hold_cnt≠0: decrement hold_cnt, keep the owner, re-latch the owner's data.
  3. A higher-priority req is high: switch to it, reload hold_cnt, latch its data.
  4. Otherwise keep the owner and re-latch its data.
- Lower-priority requesters never preempt an owner.
- Data is latched once per frame, so changes to req_data mid-frame never tear the display.
- Display output:
  - In SHOW, an drives a single 0 at bit idx, and seg = glyph(latched nibble idx).
  - In IDLE, an=4'b1111 and seg=7'b1111111, while idx keeps advancing.
- Glyphs: hex 0–F. Examples: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001.

## Timing
- Reset values: an=4'b1111, seg=7'b1111111, grant=0, idx=0, state IDLE, hold_cnt=0, data latch 0.
- rst has priority over scan_tick in the same cycle. Reset mid-frame blanks the display on the next edge and restarts from idx=0.
- All outputs are registered. Outputs for the new digit appear on the edge that samples scan_tick, i.e. one cycle of latency.
- At a boundary edge, grant, the data latch and digit 0 of the new frame all update together. Digit 0 therefore already shows the new owner's data.
- Back-to-back scan_ticks on consecutive cycles are legal; each one advances one digit.
- grant is held stable for the whole frame and changes only on boundary edges or reset.

## Structure
- Shared package display_pkg holds:
  - DIGITS=4;
  - active-low constants BLANK_SEG=7'h7F and ALL_OFF_AN=4'hF;
  - the 16-entry glyph table.
- Sub-module seg7_decode: a combinational nibble→seg decoder that indexes the package table. All arbitration, scan and state logic stays in this module.

## Test plan
- **Reset:** hold rst 2 cycles while pulsing scan_tick. Required: an=1111, seg=1111111, grant=000 throughout, and idx starts at 0 after release.
- **Single requester:** raise req[1] with data 16'h1234.
  - Required at the next boundary: grant=010, an=1110, seg=0011001 ("4").
  - Following ticks: an=1101 with seg=0110000, then an=1011 with seg=0100100, then an=0111 with seg=1111001.
- **Hold time:** HOLD_FRAMES=2, and req[2] is granted at boundary B0. Raise req[0] one cycle later.
  - Required: grant stays 100 across B1, then becomes 001 at B2.
- **Owner drop:** owner req[0] falls while req[2] is high. Required: grant=100 at the next boundary regardless of hold_cnt.
  - Then drop req[2] with nothing else pending. Required: grant=000 and a blank display at the following boundary.
- **Tear-free update:** change the owner's req_data from 16'h1234 to 16'h5678 after digit 1 has been displayed.
  - Required: digits 2 and 3 still show 2 and 1; digit 0 of the next frame shows 8.
- **Reset mid-frame:** assert rst at idx=2 during SHOW, with scan_tick in the same cycle. Required: reset values on the next edge, and the scan restarts at idx=0.
